// File: rtl/if_id_hs.sv
// ---------------------------------------------------------------------------
// if_id_hs -- fetch-to-decode pipeline register
//
// Carries a PC/instruction pair from fetch to decode with a valid/ready
// handshake, one beat per cycle, in order. Decode back-pressure stalls fetch
// without dropping or duplicating beats. A synchronous flush kills every held
// beat and zeroes the decode-side data. A saturating counter records the
// number of cycles in which decode held off a valid beat.
//
// Build option:
//   IF_ID_SKID_EN  defined   -> adds a skid register pair; if_ready is taken
//                               from the skid-empty flop, so there is no
//                               combinational path from id_ready to if_ready.
//                  undefined -> no skid; if_ready = !id_valid || id_ready.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   flush      in   1            synchronous kill of all held beats
//   if_valid   in   1            fetch presents a beat
//   if_ready   out  1            block accepts a beat this cycle
//   if_pc      in   PC_W         fetch PC
//   if_inst    in   INST_W       fetch instruction
//   id_valid   out  1            decode beat valid (registered)
//   id_ready   in   1            decode consumes the beat this cycle
//   id_pc      out  PC_W         decode PC (registered)
//   id_inst    out  INST_W       decode instruction (registered)
//   stall_cnt  out  STALL_CNT_W  saturating count of back-pressure cycles
// ---------------------------------------------------------------------------
module if_id_hs #(
    parameter int PC_W        = 32,
    parameter int INST_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [PC_W-1:0]        if_pc,
    input  logic [INST_W-1:0]      if_inst,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [PC_W-1:0]        id_pc,
    output logic [INST_W-1:0]      id_inst,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic                   r_id_valid;
    logic [PC_W-1:0]        r_id_pc;
    logic [INST_W-1:0]      r_id_inst;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_accept;
    logic w_main_free;
    logic w_stall;

    // Main register can take a new beat when empty or drained this cycle.
    assign w_main_free = !r_id_valid || id_ready;
    assign w_stall     = r_id_valid && !id_ready;
    assign w_accept    = if_valid && if_ready;

`ifdef IF_ID_SKID_EN
    logic              r_skid_valid;
    logic [PC_W-1:0]   r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;

    // Driven purely from a flop: id_ready never reaches if_ready in the
    // same cycle.
    assign if_ready = !r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_valid   <= 1'b0;
            r_id_pc      <= '0;
            r_id_inst    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= '0;
        end else if (flush) begin
            // Flush beats any simultaneous accept: the incoming beat is dropped.
            r_id_valid   <= 1'b0;
            r_id_pc      <= '0;
            r_id_inst    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                // Skid is older than anything fetch offers; it goes first.
                // if_ready is low while the skid is full, so no accept here.
                r_id_valid   <= 1'b1;
                r_id_pc      <= r_skid_pc;
                r_id_inst    <= r_skid_inst;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= if_pc;
                r_id_inst  <= if_inst;
            end else begin
                // Drained with nothing behind it; data keeps its last value.
                r_id_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is stalled: park the accepted beat in the skid.
            r_skid_valid <= 1'b1;
            r_skid_pc    <= if_pc;
            r_skid_inst  <= if_inst;
        end
    end
`else
    assign if_ready = w_main_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
        end else if (flush) begin
            // Flush beats any simultaneous accept: the incoming beat is dropped.
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
        end else if (w_main_free) begin
            if (w_accept) begin
                r_id_valid <= 1'b1;
                r_id_pc    <= if_pc;
                r_id_inst  <= if_inst;
            end else begin
                // Drained with nothing behind it; data keeps its last value.
                r_id_valid <= 1'b0;
            end
        end
    end
`endif

    // Counts stalled edges regardless of flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
    end

    assign id_valid  = r_id_valid;
    assign id_pc     = r_id_pc;
    assign id_inst   = r_id_inst;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_hs.sv
// ---------------------------------------------------------------------------
// tb_if_id_hs -- directed self-checking bench for if_id_hs.
// The DUT is built with STALL_CNT_W=4 so the counter saturates quickly.
// Works for both builds; skid-specific stimulus sits under IF_ID_SKID_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_id_hs;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int SC_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              if_valid;
    logic              if_ready;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_valid;
    logic              id_ready;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic [SC_W-1:0]   stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    if_id_hs #(.PC_W(PC_W), .INST_W(INST_W), .STALL_CNT_W(SC_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst);
        chk({tag, ".valid"}, {63'd0, id_valid}, {63'd0, v});
        chk({tag, ".pc"},    {32'd0, id_pc},    {32'd0, pc});
        chk({tag, ".inst"},  {32'd0, id_inst},  {32'd0, inst});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        rst = 1'b0;
        #1;
        // Reset state
        chk_out("reset", 1'b0, 32'h0, 32'h0);
        chk("reset.stall", {60'd0, stall_cnt}, 64'd0);
        chk("reset.if_ready", {63'd0, if_ready}, 64'd1);

        // Four back-to-back beats, decode always ready
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 32'(8'h11 * (i + 1)), 1'b1, 1'b0);
            #1;
            chk("b2b.if_ready", {63'd0, if_ready}, 64'd1);
            tick();
            chk_out("b2b", 1'b1, 32'(4 * i), 32'(8'h11 * (i + 1)));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("drain", 1'b0, 32'hC, 32'h44);

        // Stall: 0x100 in main, decode holds off for 5 edges
        drive(1'b1, 32'h100, 32'hAA, 1'b1, 1'b0);
        tick();
        chk_out("st.load", 1'b1, 32'h100, 32'hAA);
        drive(1'b1, 32'h104, 32'hBB, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
`ifdef IF_ID_SKID_EN
            // 0x104 was accepted into the skid on the first stalled edge
            if (i == 0) if_valid = 1'b0;
`endif
            chk_out("st.hold", 1'b1, 32'h100, 32'hAA);
            chk("st.if_ready", {63'd0, if_ready}, 64'd0);
        end
        chk("st.cnt5", {60'd0, stall_cnt}, 64'd5);
        id_ready = 1'b1;
        tick();
        chk_out("st.next", 1'b1, 32'h104, 32'hBB);
        chk("st.cnt_hold", {60'd0, stall_cnt}, 64'd5);
        if_valid = 1'b0;
        tick();
        chk_out("st.nodup", 1'b0, 32'h104, 32'hBB);
        chk("st.if_ready_back", {63'd0, if_ready}, 64'd1);

        // Flush during stall: 0x200 main, 0x204 skid (skid build)
        drive(1'b1, 32'h200, 32'hC0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h204, 32'hC4, 1'b0, 1'b0);
        tick();
        chk_out("fl.pre", 1'b1, 32'h200, 32'hC0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        chk_out("fl.kill", 1'b0, 32'h0, 32'h0);
        chk("fl.cnt", {60'd0, stall_cnt}, 64'd7);
        flush = 1'b0;
        #1;
        chk("fl.if_ready", {63'd0, if_ready}, 64'd1);
        drive(1'b1, 32'h300, 32'hD0, 1'b1, 1'b0);
        tick();
        chk_out("fl.new", 1'b1, 32'h300, 32'hD0);
        if_valid = 1'b0;
        tick();
        chk_out("fl.gone", 1'b0, 32'h300, 32'hD0);

        // Flush together with an offered beat: 0x400 must never appear
        drive(1'b1, 32'h400, 32'hE0, 1'b1, 1'b1);
        tick();
        chk_out("fla.kill", 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_out("fla.never", 1'b0, 32'h0, 32'h0);

        // Saturation: counter is 7, stall long enough to pass all-ones
        drive(1'b1, 32'h500, 32'hF0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 7)  chk("sat.14", {60'd0, stall_cnt}, 64'd14);
            if (i == 8)  chk("sat.15", {60'd0, stall_cnt}, 64'd15);
        end
        chk("sat.stick", {60'd0, stall_cnt}, 64'd15);
        chk_out("sat.hold", 1'b1, 32'h500, 32'hF0);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk_out("arst", 1'b0, 32'h0, 32'h0);
        chk("arst.stall", {60'd0, stall_cnt}, 64'd0);
        chk("arst.if_ready", {63'd0, if_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h600, 32'h66, 1'b1, 1'b0);
        tick();
        chk_out("rst.restart", 1'b1, 32'h600, 32'h66);
        if_valid = 1'b0;
        tick();
        chk_out("rst.drain", 1'b0, 32'h600, 32'h66);
        chk("rst.stall", {60'd0, stall_cnt}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_hs.md
# if_id_hs

Parametrised fetch-to-decode pipeline register with a valid/ready handshake, synchronous flush and a saturating stall counter. It carries a PC/instruction pair from the fetch stage to the decode stage in a one-beat-per-cycle, in-order stream. Downstream back-pressure stalls fetch without dropping or duplicating instructions, and a branch/exception flush kills everything in flight.

## Interface
Parameters:
- PC_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- STALL_CNT_W, 16, stall counter width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of every held beat.
- if_valid  input  1  fetch presents a beat.
- if_ready  output  1  block accepts a beat this cycle.
- if_pc  input  PC_W  fetch PC.
- if_inst  input  INST_W  fetch instruction.
- id_valid  output  1  decode beat valid.
- id_ready  input  1  decode consumes the beat this cycle.
- id_pc  output  PC_W  decode PC.
- id_inst  output  INST_W  decode instruction.
- stall_cnt  output  STALL_CNT_W  saturating count of back-pressure cycles.

## Operation
- Accept on the upstream side: if_valid && if_ready at the clock edge.
- Consume on the downstream side: id_valid && id_ready at the clock edge.
- Main register: id_valid, id_pc and id_inst are registered outputs.
- Main register loads an accepted beat when it is empty or is being consumed in the same cycle.
- Main register holds its value while id_valid && !id_ready. id_pc and id_inst must stay stable while stalled.
- If a consume happens with no new beat available, id_valid drops to 0. id_pc and id_inst keep their last value.
- Flush: on the next edge, id_valid and all internal valid bits go to 0, and id_pc and id_inst go to zero.
- Flush wins over a simultaneous accept. The incoming beat is dropped, and if_ready still reads as defined, so fetch must treat the beat as gone.
- Flush with no beats held has no effect beyond zeroing the data outputs.
- stall_cnt increments on every edge where id_valid && !id_ready. It saturates at all-ones and never wraps.
- stall_cnt clears only on rst; flush does not clear it.
- Beat order is always preserved. Every accepted, unflushed beat appears on the downstream side exactly once.

## Timing
- Reset values:
  - id_valid = 0, id_pc = 0, id_inst = 0, stall_cnt = 0.
  - Skid buffer empty.
  - if_ready = 1 once rst is released.
- Latency: a beat accepted at edge N is presented with id_valid = 1 after edge N; throughput is 1 beat/cycle.
- Reset asserted mid-stream clears all state immediately, without waiting for clk, and discards held beats.
- Flush asserted at edge N: id_valid = 0 after edge N. A beat accepted at edge N+1 appears after edge N+1.

## Configuration
- Macro: IF_ID_SKID_EN.
- Defined: a second register pair (skid) is added, and if_ready is a registered output equal to "skid empty".
  - When the main register is stalled and a beat is accepted, that beat goes to the skid and if_ready drops after that edge.
  - When id_ready returns, the skid moves into the main register at that edge and if_ready rises after that edge.
  - There is no combinational path from id_ready to if_ready.
- Undefined: there is no skid, and if_ready = !id_valid || id_ready combinationally.
- Both builds have identical beat ordering, flush behaviour and stall_cnt behaviour.

## Test plan
- Reset release, then 4 beats back-to-back with id_ready=1:
  - pc 0x0,0x4,0x8,0xC and inst 0x11,0x22,0x33,0x44.
  - Each appears one cycle after acceptance, with no gaps.
- id_ready=0 for 5 cycles with pc 0x100 held:
  - id_pc stays 0x100 and stall_cnt = 5.
  - No beat is lost or duplicated after id_ready=1 returns.
  - With IF_ID_SKID_EN, pc 0x104 sits in the skid and if_ready=0 from the second stalled cycle.
- flush during a stall with beats 0x200 (main) and 0x204 (skid):
  - Next cycle id_valid=0 and id_pc=0.
  - A new beat 0x300 appears one cycle after its acceptance.
- flush and if_valid together with pc 0x400: 0x400 never appears downstream.
- Hold id_ready=0 for more than 2^STALL_CNT_W cycles (STALL_CNT_W=4 build): stall_cnt sticks at 0xF.
- Assert rst asynchronously between edges mid-stream: outputs go to reset values immediately, and the stream restarts cleanly after release.
